// File: rtl/ir_seq_gen_pkg.sv
// rtl/ir_seq_gen_pkg.sv - shared types and default timing for the IR sequence generator
package ir_seq_pkg;

  typedef enum logic [1:0] {
    IR_IDLE = 2'd0,
    IR_RUN  = 2'd1,
    IR_GAP  = 2'd2
  } ir_state_e;

  localparam int PULSE_W = 13;
  localparam int D1      = 3;
  localparam int D2      = 7;
  localparam int GAP_CYC = 2;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/ir_seq_gen_if.sv
// rtl/ir_seq_gen_if.sv - control and sensor-line bundle between a requester and the generator
interface ir_seq_gen_if;
  logic start;
  logic dir;
  logic abort;
  logic busy;
  logic done;
  logic IR1;
  logic IR2;
  logic IR3;

  modport master (output start, dir, abort, input busy, done, IR1, IR2, IR3);
  modport slave  (input start, dir, abort, output busy, done, IR1, IR2, IR3);
endinterface

// File: rtl/ir_slot.sv
// rtl/ir_slot.sv - window comparator: active while offset <= t < offset + width
module ir_slot #(
  parameter int TW = 5
) (
  input  logic [TW-1:0] t,
  input  logic [TW-1:0] offset,
  input  logic [TW-1:0] width,
  output logic          active
);

  // One extra bit keeps offset + width from wrapping.
  logic [TW:0] win_end;

  assign win_end = {1'b0, offset} + {1'b0, width};
  assign active  = ({1'b0, t} >= {1'b0, offset}) && ({1'b0, t} < win_end);

endmodule

// File: rtl/ir_seq_gen.sv
// rtl/ir_seq_gen.sv - drives three staggered active-low IR pulses, forward or reverse order
module ir_seq_gen #(
  parameter int PULSE_W = ir_seq_pkg::PULSE_W,
  parameter int D1      = ir_seq_pkg::D1,
  parameter int D2      = ir_seq_pkg::D2,
  parameter int GAP_CYC = ir_seq_pkg::GAP_CYC
) (
  input  logic         CLK,
  input  logic         RSTn,
  ir_seq_gen_if.slave  io
);

  import ir_seq_pkg::ir_state_e;
  import ir_seq_pkg::IR_IDLE;
  import ir_seq_pkg::IR_RUN;
  import ir_seq_pkg::IR_GAP;
  import ir_seq_pkg::DIR_FWD;
  import ir_seq_pkg::DIR_REV;

  localparam int            TW      = $clog2(D2 + PULSE_W + GAP_CYC + 1);
  localparam logic [TW-1:0] RUN_END = TW'(D2 + PULSE_W);
  localparam logic [TW-1:0] GAP_END = TW'(GAP_CYC - 1);

  ir_state_e     state_q;
  logic [TW-1:0] t_q;
  logic          dir_q;
  logic          busy_q;
  logic          done_q;
  logic          ir1_q, ir2_q, ir3_q;

  logic          gap_last;
  logic          accept;
  logic [TW-1:0] t_d;
  logic          dir_d;
  logic          a_act, b_act, c_act;
  logic          ir1_d, ir2_d, ir3_d;

  // Slots are evaluated at the timer value being loaded, so each IR flop
  // already holds the level for the cycle it is entering.
  always_comb begin
    gap_last = (state_q == IR_GAP) && (t_q == GAP_END);
    accept   = io.start && !io.abort && ((state_q == IR_IDLE) || gap_last);
    t_d      = (state_q == IR_RUN) ? t_q + TW'(1) : '0;
    dir_d    = accept ? io.dir : dir_q;
    ir1_d    = !((dir_d == DIR_REV) ? c_act : a_act);
    ir2_d    = !b_act;
    ir3_d    = !((dir_d == DIR_FWD) ? c_act : a_act);
  end

  ir_slot #(.TW(TW)) u_slot_a (
    .t      (t_d),
    .offset (TW'(0)),
    .width  (TW'(PULSE_W)),
    .active (a_act)
  );

  ir_slot #(.TW(TW)) u_slot_b (
    .t      (t_d),
    .offset (TW'(D1)),
    .width  (TW'(PULSE_W)),
    .active (b_act)
  );

  ir_slot #(.TW(TW)) u_slot_c (
    .t      (t_d),
    .offset (TW'(D2)),
    .width  (TW'(PULSE_W)),
    .active (c_act)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IR_IDLE;
      t_q     <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ir1_q   <= 1'b1;
      ir2_q   <= 1'b1;
      ir3_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IR_IDLE: begin
          if (accept) begin
            state_q <= IR_RUN;
            t_q     <= '0;
            dir_q   <= io.dir;
            busy_q  <= 1'b1;
            ir1_q   <= ir1_d;
            ir2_q   <= ir2_d;
            ir3_q   <= ir3_d;
          end
        end
        IR_RUN: begin
          if (io.abort) begin
            state_q <= IR_IDLE;
            t_q     <= '0;
            busy_q  <= 1'b0;
            ir1_q   <= 1'b1;
            ir2_q   <= 1'b1;
            ir3_q   <= 1'b1;
          end else if (t_d == RUN_END) begin
            state_q <= IR_GAP;
            t_q     <= '0;
            ir1_q   <= 1'b1;
            ir2_q   <= 1'b1;
            ir3_q   <= 1'b1;
          end else begin
            t_q   <= t_d;
            ir1_q <= ir1_d;
            ir2_q <= ir2_d;
            ir3_q <= ir3_d;
          end
        end
        IR_GAP: begin
          if (io.abort) begin
            state_q <= IR_IDLE;
            t_q     <= '0;
            busy_q  <= 1'b0;
          end else if (gap_last) begin
            done_q <= 1'b1;
            t_q    <= '0;
            // Completion edge doubles as the idle sample point for back-to-back runs.
            if (accept) begin
              state_q <= IR_RUN;
              dir_q   <= io.dir;
              ir1_q   <= ir1_d;
              ir2_q   <= ir2_d;
              ir3_q   <= ir3_d;
            end else begin
              state_q <= IR_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            t_q <= t_q + TW'(1);
          end
        end
        default: begin
          state_q <= IR_IDLE;
          t_q     <= '0;
          busy_q  <= 1'b0;
          ir1_q   <= 1'b1;
          ir2_q   <= 1'b1;
          ir3_q   <= 1'b1;
        end
      endcase
    end
  end

  assign io.busy = busy_q;
  assign io.done = done_q;
  assign io.IR1  = ir1_q;
  assign io.IR2  = ir2_q;
  assign io.IR3  = ir3_q;

endmodule

// File: tb/tb_ir_seq_gen.sv
// tb/tb_ir_seq_gen.sv - directed self-checking bench for ir_seq_gen with default timing
module tb_ir_seq_gen;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  ir_seq_gen_if bus ();

  ir_seq_gen dut (
    .CLK  (clk),
    .RSTn (rst_n),
    .io   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {IR1, IR2, IR3, busy, done} expected k edges after the start edge.
  function automatic logic [4:0] exp_vec(int k, logic rev);
    logic a, b, c;
    a = (k >= 0) && (k < 13);
    b = (k >= 3) && (k < 16);
    c = (k >= 7) && (k < 20);
    exp_vec = {~(rev ? c : a), ~b, ~(rev ? a : c), (k >= 0) && (k < 22), (k == 22)};
  endfunction

  function automatic logic [4:0] got_vec();
    got_vec = {bus.IR1, bus.IR2, bus.IR3, bus.busy, bus.done};
  endfunction

  task automatic test_reset();
    logic [4:0] got;
    got = got_vec();
    n_checks++;
    if (got !== 5'b11100) $display("FAIL reset got=%b exp=%b", got, 5'b11100);
    else n_pass++;
  endtask

  task automatic test_dir(input logic rev);
    logic [4:0] got;
    @(negedge clk);
    bus.start = 1'b1;
    bus.dir   = rev;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      got = got_vec();
      n_checks++;
      if (got !== exp_vec(k, rev))
        $display("FAIL dir%0d k=%0d got=%b exp=%b", rev, k, got, exp_vec(k, rev));
      else n_pass++;
    end
  endtask

  task automatic test_ignored_start();
    logic [4:0] got;
    int         dones;
    dones = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.dir   = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      @(negedge clk);
      bus.start = (k == 4) || (k == 20);
      bus.dir   = (k == 4) || (k == 20);
      got = got_vec();
      dones += int'(bus.done);
      n_checks++;
      if (got !== exp_vec(k, 1'b0))
        $display("FAIL ignored_start k=%0d got=%b exp=%b", k, got, exp_vec(k, 1'b0));
      else n_pass++;
    end
    bus.dir = 1'b0;
    n_checks++;
    if (dones !== 1) $display("FAIL ignored_start_dones got=%0d exp=1", dones);
    else n_pass++;
  endtask

  task automatic test_abort();
    logic [4:0] got, exp;
    @(negedge clk);
    bus.start = 1'b1;
    bus.dir   = 1'b0;
    for (int k = 0; k < 37; k++) begin
      @(posedge clk);
      @(negedge clk);
      bus.start = (k == 11);
      bus.abort = (k == 8);
      if (k < 9)       exp = exp_vec(k, 1'b0);
      else if (k < 12) exp = 5'b11100;
      else             exp = exp_vec(k - 12, 1'b0);
      got = got_vec();
      n_checks++;
      if (got !== exp) $display("FAIL abort k=%0d got=%b exp=%b", k, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] got;
    @(negedge clk);
    bus.start = 1'b1;
    bus.dir   = 1'b0;
    repeat (6) @(posedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 got = got_vec();
    n_checks++;
    if (got !== 5'b11100) $display("FAIL async_reset got=%b exp=%b", got, 5'b11100);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    test_dir(1'b0);
  endtask

  task automatic test_back_to_back();
    logic [4:0] got, exp;
    @(negedge clk);
    bus.start = 1'b1;
    bus.dir   = 1'b0;
    for (int k = 0; k < 47; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 10) bus.dir = 1'b1;
      if (k == 22) bus.start = 1'b0;
      if (k < 22)       exp = exp_vec(k, 1'b0);
      else if (k == 22) exp = exp_vec(0, 1'b1) | 5'b00001;
      else              exp = exp_vec(k - 22, 1'b1);
      got = got_vec();
      n_checks++;
      if (got !== exp) $display("FAIL back_to_back k=%0d got=%b exp=%b", k, got, exp);
      else n_pass++;
    end
    bus.dir = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.dir   = 1'b0;
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_dir(1'b0);
    test_dir(1'b1);
    test_ignored_start();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ir_seq_gen.md
# ir_seq_gen

Active-low IR sensor sequence generator: the encoder counterpart to the direction decoder `Dir_test`. On a start request it drives three staggered, fixed-width active-low pulses onto IR1..IR3. Forward order is 1→2→3; reverse order is 3→2→1. It sits in front of `Dir_test` for on-board self-test and for closed-loop simulation, replacing the hand-written stimulus tasks.

## Interface
Parameters:
- `PULSE_W`, 13: low-pulse width of each sensor, in cycles (≥1).
- `D1`, 3: offset of the second pulse from the first, in cycles (≥1).
- `D2`, 7: offset of the third pulse from the first, in cycles (>D1).
- `GAP_CYC`, 2: idle cycles after the last pulse rises, before completion (≥1).

Ports:
- `CLK`, in, 1: the only clock. All logic is rising-edge.
- `RSTn`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request one sequence. Sampled only in IDLE.
- `dir`, in, 1: direction, latched at start. 0 = forward (IR1, IR2, IR3); 1 = reverse (IR3, IR2, IR1).
- `abort`, in, 1: synchronous cancel of any sequence in progress.
- `busy`, out, 1: high in RUN and GAP.
- `done`, out, 1: one-cycle pulse when a sequence completes normally.
- `IR1`, `IR2`, `IR3`, out, 1 each: sensor lines, active-low, registered.

## Operation
- States: IDLE, RUN, GAP. Timer `t`, width $clog2(D2+PULSE_W+GAP_CYC+1), unsigned.
- Logical slots A, B, C:
  - A is low for t in [0, PULSE_W).
  - B is low for t in [D1, D1+PULSE_W).
  - C is low for t in [D2, D2+PULSE_W).
  - Overlapping slots are legal and expected with the defaults.
- Slot mapping: forward gives A→IR1, B→IR2, C→IR3. Reverse gives A→IR3, B→IR2, C→IR1. IR2 is always the middle slot.
- IDLE + start=1 + abort=0:
  - latch `dir`, clear t, enter RUN;
  - the slot-A line falls on that same edge.
- RUN: t increments each cycle. When t reaches D2+PULSE_W, go to GAP with all lines high and reset t.
- GAP: after GAP_CYC cycles, go to IDLE with `done`=1 for exactly one cycle.
- start outside IDLE is ignored, not queued. The `dir` input is ignored while busy.
- abort=1 in RUN or GAP: on the next edge, all lines go high, state goes to IDLE, busy=0, and no done.
- abort=1 in IDLE blocks a coincident start.
- start in the IDLE cycle where done=1 is accepted, so sequences can run back-to-back.

## Timing
- Reset values: IR1=IR2=IR3=1, busy=0, done=0, state IDLE, t=0, latched dir=0.
- Reset asserted mid-sequence forces all outputs to these values immediately, regardless of the clock.
- With start sampled at edge N:
  - the A line is low on edges N through N+PULSE_W−1 and rises at N+PULSE_W;
  - the B line falls at N+D1 and rises at N+D1+PULSE_W;
  - the C line falls at N+D2 and rises at N+D2+PULSE_W.
- busy rises at edge N and falls at N+D2+PULSE_W+GAP_CYC, the same edge where done rises. done falls one edge later.
- Total sequence latency from start to done is D2+PULSE_W+GAP_CYC cycles; with defaults this is 22.
- Outputs are glitch-free: every IR line comes directly from a flop.

## Structure
- Package `ir_seq_pkg` holds:
  - the state enum (`IR_IDLE`, `IR_RUN`, `IR_GAP`);
  - the default constants (PULSE_W, D1, D2, GAP_CYC);
  - the direction encodings `DIR_FWD`=0 and `DIR_REV`=1.
- One sub-module, `ir_slot`: a window comparator with inputs t, offset, and width, producing `active`. It is instantiated three times for A, B and C. The top level handles the FSM, the timer, the slot-to-IR mapping and the output flops.

## Test plan
1. Forward, defaults, start at edge 0:
   - IR1 is low on edges 0–12, IR2 on 3–15, IR3 on 7–19;
   - done=1 for exactly one cycle at edge 22;
   - busy is high on edges 0–21.
2. Reverse, dir=1: IR3 is low on 0–12, IR2 on 3–15, IR1 on 7–19. Connected to `Dir_test`, the decoder reports the opposite direction from test 1.
3. start pulsed at edges 5 and 21 during a sequence → no effect: timing is identical to test 1 and only one done pulse occurs.
4. abort at edge 9 → all IR lines high and busy=0 after edge 9, no done. A new start at edge 12 produces a full, correct sequence.
5. RSTn driven low mid-RUN, asynchronously between edges → IR1..IR3 go high and busy/done go low immediately. After release, a start gives the normal sequence.
6. start held high continuously → sequences run back-to-back. The second sequence's slot-A falls on the done edge (edge 22), and the latched dir follows `dir` at each acceptance.
